// File: rtl/led_flow_ctrl.sv
// LED pattern sequencer: steps blink / flow-left / flow-right / bounce patterns
// once every STEP_TICKS accepted tick_in pulses, with mode reload and pause.
module led_flow_ctrl #(
  parameter int LED_W      = 4,
  parameter int STEP_TICKS = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick_in,
  input  logic [1:0]       mode_in,
  input  logic             pause_in,
  output logic [LED_W-1:0] led_out,
  output logic             step_pulse
);

  localparam logic [1:0] MODE_BLINK  = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic [7:0]       LAST_TICK = 8'(STEP_TICKS - 1);
  localparam logic [LED_W-1:0] LED_LSB   = LED_W'(1);
  localparam logic [LED_W-1:0] LED_MSB   = {1'b1, {(LED_W-1){1'b0}}};

  logic [1:0]       mode_q, mode_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;

  logic [LED_W-1:0] reload_led;
  logic [LED_W-1:0] step_led;
  logic             step_dir;

  always_comb begin
    reload_led = '0;
    case (mode_in)
      MODE_BLINK:  reload_led = '0;
      MODE_LEFT:   reload_led = LED_LSB;
      MODE_RIGHT:  reload_led = LED_MSB;
      MODE_BOUNCE: reload_led = LED_LSB;
      default:     reload_led = '0;
    endcase
  end

  // Bounce turns around on the end LED itself, so each end is lit only once per pass.
  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    case (mode_q)
      MODE_BLINK:  step_led = ~led_q;
      MODE_LEFT:   step_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      MODE_RIGHT:  step_led = {led_q[0], led_q[LED_W-1:1]};
      MODE_BOUNCE: begin
        if (!dir_q) begin
          if (led_q[LED_W-1]) begin
            step_dir = 1'b1;
            step_led = led_q >> 1;
          end else begin
            step_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            step_dir = 1'b0;
            step_led = led_q << 1;
          end else begin
            step_led = led_q >> 1;
          end
        end
      end
      default:     step_led = led_q;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    tick_cnt_d = tick_cnt_q;
    dir_d      = dir_q;
    led_d      = led_q;
    step_d     = 1'b0;
    if (mode_in != mode_q) begin
      mode_d     = mode_in;
      tick_cnt_d = '0;
      dir_d      = 1'b0;
      led_d      = reload_led;
    end else if (!pause_in && tick_in) begin
      if (tick_cnt_q == LAST_TICK) begin
        tick_cnt_d = '0;
        led_d      = step_led;
        dir_d      = step_dir;
        step_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q     <= '0;
      tick_cnt_q <= '0;
      dir_q      <= 1'b0;
      led_q      <= '0;
      step_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
      step_q     <= step_d;
    end
  end

  assign led_out    = led_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Bench for led_flow_ctrl: two instances (STEP_TICKS 1 and 3) share stimulus and are
// checked every cycle against a position/phase model, plus directed pattern checks.
module tb_led_flow_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [1:0]   mode;
  logic         pause;
  logic [W-1:0] led_a, led_b;
  logic         pulse_a, pulse_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: 0 -> STEP_TICKS=1, 1 -> STEP_TICKS=3
  int   m_steps [2] = '{1, 3};
  int   m_mode  [2];
  int   m_cnt   [2];
  int   m_phase [2];
  logic m_pulse [2];

  led_flow_ctrl #(.LED_W(W), .STEP_TICKS(1)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .tick_in(tick), .mode_in(mode),
    .pause_in(pause), .led_out(led_a), .step_pulse(pulse_a)
  );

  led_flow_ctrl #(.LED_W(W), .STEP_TICKS(3)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .tick_in(tick), .mode_in(mode),
    .pause_in(pause), .led_out(led_b), .step_pulse(pulse_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Pattern as a function of how many steps were taken since the last reload.
  function automatic logic [W-1:0] model_led(input int md, input int ph);
    int pos;
    int k;
    logic [W-1:0] v;
    v = '0;
    case (md)
      0: v = (ph % 2 == 1) ? '1 : '0;
      1: v[ph % W] = 1'b1;
      2: v[W - 1 - (ph % W)] = 1'b1;
      default: begin
        k = ph % (2 * W - 2);
        pos = (k < W) ? k : (2 * W - 2 - k);
        v[pos] = 1'b1;
      end
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_phase[i] = 0; m_pulse[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic tk, input logic [1:0] md, input logic ps);
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 1'b0;
      if (int'(md) != m_mode[i]) begin
        m_mode[i] = int'(md); m_cnt[i] = 0; m_phase[i] = 0;
      end else if (!ps && tk) begin
        m_cnt[i]++;
        if (m_cnt[i] == m_steps[i]) begin
          m_cnt[i] = 0; m_phase[i]++; m_pulse[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_models();
    check("led_a",   16'(led_a),   16'(model_led(m_mode[0], m_phase[0])));
    check("pulse_a", 16'(pulse_a), 16'(m_pulse[0]));
    check("led_b",   16'(led_b),   16'(model_led(m_mode[1], m_phase[1])));
    check("pulse_b", 16'(pulse_b), 16'(m_pulse[1]));
  endtask

  // One clock: inputs applied now (away from the edge), sampled 1 time unit after the edge.
  task automatic cyc(input logic tk, input logic [1:0] md, input logic ps);
    tick = tk; mode = md; pause = ps;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(tk, md, ps);
    #1;
    check_models();
  endtask

  logic [W-1:0] bounce_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    rst = 1'b1; tick = 1'b0; mode = 2'b01; pause = 1'b0;
    model_reset();

    // Reset then flow left
    #12;
    check("rst_led_a", 16'(led_a), 16'h0);
    check("rst_pulse_a", 16'(pulse_a), 16'h0);
    cyc(1'b0, 2'b01, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 2'b01, 1'b0);
    check("flow_reload", 16'(led_a), 16'b0001);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'b01, 1'b0);
      check("flow_pulse", 16'(pulse_a), 16'h1);
    end
    check("flow_final", 16'(led_a), 16'b0010);
    cyc(1'b0, 2'b01, 1'b0);
    check("flow_pulse_end", 16'(pulse_a), 16'h0);

    // Bounce ends
    cyc(1'b0, 2'b11, 1'b0);
    check("bounce_reload", 16'(led_a), 16'b0001);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 2'b11, 1'b0);
      check("bounce_seq", 16'(led_a), 16'(bounce_exp[i]));
      for (int j = 0; j < 4; j++) cyc(1'b0, 2'b11, 1'b0);
    end

    // Divider and pause on the STEP_TICKS=3 instance
    cyc(1'b0, 2'b10, 1'b0);
    check("div_reload", 16'(led_b), 16'b1000);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 2'b10, 1'b0);
      if (i == 2) check("div_step1", 16'(led_b), 16'b0100);
      cyc(1'b0, 2'b10, 1'b0);
    end
    check("div_step2", 16'(led_b), 16'b0010);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'b10, 1'b1);
      check("pause_pulse", 16'(pulse_b), 16'h0);
    end
    check("pause_hold", 16'(led_b), 16'b0010);
    cyc(1'b1, 2'b10, 1'b0);
    check("resume_cnt", 16'(led_b), 16'b0010);

    // Simultaneous mode change and tick
    cyc(1'b0, 2'b01, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    check("sim_led", 16'(led_a), 16'b0000);
    check("sim_pulse", 16'(pulse_a), 16'h0);
    cyc(1'b1, 2'b00, 1'b0);
    check("blink_on", 16'(led_a), 16'b1111);
    cyc(1'b1, 2'b00, 1'b0);
    check("blink_off", 16'(led_a), 16'b0000);

    // Async reset mid-pattern
    cyc(1'b0, 2'b01, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    check("pre_rst", 16'(led_a), 16'b0100);
    tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_led", 16'(led_a), 16'h0);
    check("async_pulse", 16'(pulse_a), 16'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b0, 2'b01, 1'b0);
    check("post_rst", 16'(led_a), 16'b0001);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : mode;
      cyc(1'($urandom_range(0, 1)), md, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
